// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetches the word at pc over a req/ack handshake, latches it into ir
// and drives the next-PC load value. Define IFETCH_TIMEOUT_EN to add the ack watchdog.
module instr_fetch #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_consume,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] npc,
    output logic              pc_w,
    output logic              busy,
    output logic              fault
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StReq   = 2'd1;
    localparam logic [1:0] StValid = 2'd2;
    localparam logic [1:0] StFault = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic              pc_w_q, pc_w_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

`ifdef IFETCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        npc_d       = npc_q;
        pc_w_d      = 1'b0;
        fault_d     = fault_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
`ifdef IFETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                // A redirect outranks a simultaneous start; the start is dropped.
                if (redirect) begin
                    npc_d  = redirect_addr;
                    pc_w_d = 1'b1;
                end else if (start) begin
                    if (pc[1:0] != 2'b00) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                    end else begin
                        state_d = StReq;
                        req_d   = 1'b1;
                        addr_d  = pc;
`ifdef IFETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end

            StReq: begin
                if (imem_ack) begin
                    req_d  = 1'b0;
                    pc_w_d = 1'b1;
                    // A redirect on the ack edge also squashes the returning word.
                    if (pend_q || redirect) begin
                        npc_d   = redirect ? redirect_addr : pend_addr_q;
                        pend_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        ir_d       = imem_rdata;
                        ir_valid_d = 1'b1;
                        npc_d      = addr_q + ADDR_W'(4);
                        state_d    = StValid;
                    end
                end else begin
                    if (redirect) begin
                        pend_d      = 1'b1;
                        pend_addr_d = redirect_addr;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    if (cnt_q == CntLast) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                        req_d   = 1'b0;
                        pend_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end

            StValid: begin
                if (redirect) begin
                    npc_d  = redirect_addr;
                    pc_w_d = 1'b1;
                end
                if (ir_consume) begin
                    ir_valid_d = 1'b0;
                    state_d    = StIdle;
                end
            end

            StFault: begin
                req_d   = 1'b0;
                fault_d = 1'b1;
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StReq);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            addr_q      <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            npc_q       <= ADDR_W'(4);
            pc_w_q      <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            npc_q       <= npc_d;
            pc_w_q      <= pc_w_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
`ifdef IFETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign npc       = npc_q;
    assign pc_w      = pc_w_q;
    assign busy      = busy_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; the timeout scenario follows IFETCH_TIMEOUT_EN.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_consume;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] npc;
    logic        pc_w;
    logic        busy;
    logic        fault;

    int total = 0;
    int bad   = 0;

    instr_fetch #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .ir_valid     (ir_valid),
        .ir_consume   (ir_consume),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .npc          (npc),
        .pc_w         (pc_w),
        .busy         (busy),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; imem_ack = 0; ir_consume = 0; redirect = 0;
    endtask

    task automatic test_reset();
        reset = 1; pc = 0; imem_rdata = 0; redirect_addr = 0;
        idle_inputs();
        tick(); tick();
        total++;
        if ({imem_req, ir_valid, pc_w, busy, fault} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {imem_req, ir_valid, pc_w, busy, fault});
        end
        total++;
        if (npc !== 32'd4 || ir !== 32'd0 || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL reset_regs npc=%h ir=%h addr=%h exp 4/0/0", npc, ir, imem_addr);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_basic_fetch();
        pc = 32'h0; start = 1;
        tick();
        start = 0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_req req=%b addr=%h busy=%b exp 1/0/1", imem_req, imem_addr, busy);
        end
        imem_ack = 1; imem_rdata = 32'h20080005;
        tick();
        imem_ack = 0;
        total++;
        if (ir !== 32'h20080005 || ir_valid !== 1'b1 || npc !== 32'h4 || pc_w !== 1'b1
            || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL basic_ack ir=%h v=%b npc=%h pcw=%b req=%b exp 20080005/1/4/1/0",
                     ir, ir_valid, npc, pc_w, imem_req);
        end
        tick();
        total++;
        if (pc_w !== 1'b0 || ir_valid !== 1'b1) begin
            bad++;
            $display("FAIL basic_pcw_pulse pcw=%b v=%b exp 0/1", pc_w, ir_valid);
        end
        ir_consume = 1;
        tick();
        ir_consume = 0;
        total++;
        if (ir_valid !== 1'b0 || ir !== 32'h20080005 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_consume v=%b ir=%h busy=%b exp 0/20080005/0", ir_valid, ir, busy);
        end
    endtask

    task automatic test_delayed_ack();
        int held;
        pc = 32'h100; start = 1;
        tick();
        start = 0;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h100 && busy === 1'b1) held++;
            tick();
        end
        total++;
        if (held !== 5) begin
            bad++;
            $display("FAIL delayed_hold got=%0d exp=5", held);
        end
        imem_ack = 1; imem_rdata = 32'h8C220000;
        tick();
        imem_ack = 0;
        total++;
        if (npc !== 32'h104 || ir !== 32'h8C220000 || pc_w !== 1'b1) begin
            bad++;
            $display("FAIL delayed_ack npc=%h ir=%h pcw=%b exp 104/8c220000/1", npc, ir, pc_w);
        end
        ir_consume = 1;
        tick();
        ir_consume = 0;
    endtask

    task automatic test_redirect_in_req();
        pc = 32'h200; start = 1;
        tick();
        start = 0;
        redirect = 1; redirect_addr = 32'h80;
        tick();
        redirect_addr = 32'h40;
        tick();
        redirect = 0;
        total++;
        if (pc_w !== 1'b0 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL redir_req_hold pcw=%b req=%b exp 0/1", pc_w, imem_req);
        end
        imem_ack = 1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ack = 0;
        total++;
        if (ir_valid !== 1'b0 || npc !== 32'h40 || pc_w !== 1'b1 || ir !== 32'h8C220000
            || busy !== 1'b0) begin
            bad++;
            $display("FAIL redir_req_ack v=%b npc=%h pcw=%b ir=%h busy=%b exp 0/40/1/8c220000/0",
                     ir_valid, npc, pc_w, ir, busy);
        end
        tick();
        total++;
        if (pc_w !== 1'b0) begin
            bad++;
            $display("FAIL redir_req_pulse pcw=%b exp=0", pc_w);
        end
    endtask

    task automatic test_wrap();
        pc = 32'hFFFFFFFC; start = 1;
        tick();
        start = 0; imem_ack = 1; imem_rdata = 32'h00000013;
        tick();
        imem_ack = 0;
        total++;
        if (npc !== 32'h0 || ir_valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_npc npc=%h v=%b exp 0/1", npc, ir_valid);
        end
        // Redirect together with consume in VALID: both take effect.
        redirect = 1; redirect_addr = 32'h500; ir_consume = 1;
        tick();
        redirect = 0; ir_consume = 0;
        total++;
        if (npc !== 32'h500 || pc_w !== 1'b1 || ir_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_redir npc=%h pcw=%b v=%b exp 500/1/0", npc, pc_w, ir_valid);
        end
        tick();
    endtask

    task automatic test_redirect_start_idle();
        pc = 32'h10; start = 1; redirect = 1; redirect_addr = 32'h300;
        tick();
        start = 0; redirect = 0;
        total++;
        if (npc !== 32'h300 || pc_w !== 1'b1 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_redir npc=%h pcw=%b req=%b exp 300/1/0", npc, pc_w, imem_req);
        end
        tick();
        total++;
        if (imem_req !== 1'b0 || pc_w !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_redir_after req=%b pcw=%b busy=%b exp 0/0/0", imem_req, pc_w, busy);
        end
    endtask

    task automatic test_timeout();
        pc = 32'h40; start = 1;
        tick();
        start = 0;
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < 14; i++) tick();
        total++;
        if (fault !== 1'b0 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL tmo_edge14 fault=%b req=%b exp 0/1", fault, imem_req);
        end
        imem_ack = 1; imem_rdata = 32'h11112222;
        tick();
        imem_ack = 0;
        total++;
        if (fault !== 1'b0 || ir_valid !== 1'b1 || npc !== 32'h44) begin
            bad++;
            $display("FAIL tmo_ack15 fault=%b v=%b npc=%h exp 0/1/44", fault, ir_valid, npc);
        end
        ir_consume = 1;
        tick();
        ir_consume = 0;
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 14; i++) tick();
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early fault=%b exp=0", fault);
        end
        tick();
        total++;
        if (fault !== 1'b1 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL tmo_fault fault=%b req=%b exp 1/0", fault, imem_req);
        end
        reset = 1;
        tick();
        reset = 0;
        tick();
`else
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (fault !== 1'b0 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL noto_wait fault=%b req=%b exp 0/1", fault, imem_req);
        end
        imem_ack = 1; imem_rdata = 32'h11112222;
        tick();
        imem_ack = 0;
        total++;
        if (ir_valid !== 1'b1 || npc !== 32'h44) begin
            bad++;
            $display("FAIL noto_ack v=%b npc=%h exp 1/44", ir_valid, npc);
        end
        ir_consume = 1;
        tick();
        ir_consume = 0;
`endif
    endtask

    task automatic test_misalign();
        int req_seen;
        pc = 32'h102; start = 1;
        tick();
        start = 0;
        total++;
        if (fault !== 1'b1 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL misalign fault=%b req=%b exp 1/0", fault, imem_req);
        end
        req_seen = 0;
        pc = 32'h0; start = 1; redirect = 1; redirect_addr = 32'h700; imem_ack = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (imem_req !== 1'b0 || pc_w !== 1'b0 || fault !== 1'b1) req_seen++;
        end
        idle_inputs();
        total++;
        if (req_seen !== 0 || npc === 32'h700) begin
            bad++;
            $display("FAIL fault_sticky bad_cycles=%0d npc=%h exp 0/not-700", req_seen, npc);
        end
        reset = 1;
        tick();
        reset = 0;
        tick();
        total++;
        if (fault !== 1'b0 || npc !== 32'd4) begin
            bad++;
            $display("FAIL fault_clear fault=%b npc=%h exp 0/4", fault, npc);
        end
    endtask

    task automatic test_async_reset();
        pc = 32'h20; start = 1;
        tick();
        start = 0;
        #2 reset = 1;
        #1;
        total++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset req=%b busy=%b exp 0/0", imem_req, busy);
        end
        tick();
        reset = 0; imem_ack = 1; imem_rdata = 32'hCAFEF00D;
        tick();
        imem_ack = 0;
        total++;
        if (ir_valid !== 1'b0 || ir !== 32'h0 || pc_w !== 1'b0) begin
            bad++;
            $display("FAIL ack_after_reset v=%b ir=%h pcw=%b exp 0/0/0", ir_valid, ir, pc_w);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_delayed_ack();
        test_redirect_in_req();
        test_wrap();
        test_redirect_start_idle();
        test_timeout();
        test_misalign();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the multi-cycle CPU, directly downstream of the program counter. On a start pulse from control it fetches the word at the current PC over a req/ack instruction-memory handshake, latches it into the instruction register, and computes the next PC. It drives the PC's load value and write strobe, and takes branch/jump redirects from execute.

## Interface
- ADDR_W, 32, address width (PC and memory address)
- DATA_W, 32, instruction width
- TIMEOUT, 15, max sampled edges in REQ without ack before fault (only with the watchdog compiled in)

- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- pc  in  ADDR_W  current PC value from the program counter
- start  in  1  one-cycle pulse: fetch instruction at pc
- imem_req  out  1  memory read request, held until ack
- imem_addr  out  ADDR_W  read address, stable while imem_req=1
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  DATA_W  instruction word, valid when imem_ack=1
- ir  out  DATA_W  instruction register
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_consume  in  1  decode has taken ir
- redirect  in  1  branch/jump taken
- redirect_addr  in  ADDR_W  redirect target
- npc  out  ADDR_W  next-PC value to the PC's load input
- pc_w  out  1  one-cycle write strobe to the PC
- busy  out  1  state is REQ
- fault  out  1  sticky fetch fault

## Operation
- States: IDLE, REQ, VALID, FAULT. All outputs registered.
- Reset values: state IDLE, imem_req 0, imem_addr 0, ir 0, ir_valid 0, npc 32'd4, pc_w 0, busy 0, fault 0, pending-redirect flag 0.
- IDLE:
  - start with pc[1:0]≠0 -> FAULT.
  - start with aligned pc -> REQ; imem_addr<=pc, imem_req<=1, timeout counter<=0.
- REQ:
  - On ack with no pending redirect: ir<=imem_rdata, ir_valid<=1, npc<=imem_addr+4 (mod 2^ADDR_W; 0xFFFFFFFC wraps to 0), pc_w<=1, imem_req<=0 -> VALID.
  - On ack with a pending redirect: instruction discarded (ir unchanged, ir_valid stays 0), npc<=pending target, pc_w<=1, flag cleared -> IDLE.
  - redirect while in REQ: target latched into pending register and flag set. A later redirect overwrites the target; last one wins.
  - start ignored.
- VALID:
  - ir_consume -> ir_valid<=0 -> IDLE; ir keeps its value.
  - start ignored until consumed.
- redirect in IDLE or VALID: npc<=redirect_addr, pc_w<=1; state unchanged, except that a simultaneous ir_consume in VALID also clears ir_valid and goes to IDLE.
- redirect and start together in IDLE: redirect wins, start dropped.
- FAULT: fault=1, imem_req=0, pc_w=0, all inputs ignored; only reset exits.
- pc_w is never high two consecutive cycles except on back-to-back redirects.

## Timing
- start sampled at edge 0 -> imem_req=1 and imem_addr valid after edge 0.
- ack sampled at edge k -> ir, ir_valid, npc, pc_w visible after edge k; imem_req low after edge k.
- Minimum start-to-ir_valid latency: 2 edges (ack at edge 1).
- pc_w high exactly one cycle. npc stable from that cycle until the next npc update, so the PC's negedge capture sees a settled value.
- Redirect in IDLE/VALID: 1-edge latency to npc/pc_w.
- Reset asserted mid-REQ: imem_req drops asynchronously; any ack arriving after reset is ignored.

## Configuration
- IFETCH_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) counts edges in REQ without ack.
  - After TIMEOUT such edges -> FAULT, imem_req dropped.
  - An ack on the edge the count would reach TIMEOUT counts as success.
- Undefined:
  - No counter; REQ waits indefinitely.
  - fault is raised only on misalignment.

## Test plan
- Reset, pc=0, start, ack at edge 1 with rdata=0x20080005 -> ir=0x20080005, ir_valid=1, npc=4, single pc_w pulse; ir_consume -> IDLE.
- pc=0x100, ack delayed 5 cycles -> imem_req held 5 cycles with imem_addr=0x100, busy=1; then npc=0x104.
- redirect_addr=0x40 asserted mid-REQ, then ack -> ir_valid stays 0, npc=0x40, pc_w once, state IDLE.
- start with pc=0x102 -> fault=1, imem_req never asserted; start/redirect ignored until reset.
- With IFETCH_TIMEOUT_EN and TIMEOUT=15, no ack -> fault after 15 edges; repeat with ack on the 15th edge -> success, no fault.
- pc=0xFFFFFFFC fetch -> npc=0x00000000; redirect and start together in IDLE -> npc=redirect_addr, no imem_req.
